// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32 constants and helpers for the fetch slice
//
// Purpose: default widths, the JAL opcode, enable/disable constants and the
//          J-type immediate extraction used by the fetch stage.
// Ports:   none (package).
package riscv_pkg;

   localparam int         ADDR_W_DEF = 32;
   localparam int         INST_W_DEF = 32;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic       ENABLE     = 1'b1;
   localparam logic       DISABLE    = 1'b0;

   // J-immediate, byte offset with bit 0 always zero; bit 20 is the sign.
   function automatic logic [20:0] j_imm(input logic [31:0] inst);
      return {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
   endfunction

endpackage

// File: rtl/if_fetch_fifo.sv
// rtl/if_fetch_fifo.sv - synchronous fetch FIFO with push, pop, flush and count
//
// Purpose: holds fetched {pc, instruction, pred} entries between the ICache
//          response and the IQ.
// Ports:   clk        rising-edge clock
//          rst        synchronous active-low reset
//          push       write push_data at the tail (ignored when full)
//          push_data  entry to write
//          pop        advance the head (ignored when empty)
//          flush      empty the FIFO; wins over push and pop
//          count      current occupancy, 0..DEPTH
//          head       entry at the head (valid when count != 0)
module if_fetch_fifo
#(
   parameter int DEPTH = 4,
   parameter int W     = 65
)(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic [W-1:0]           push_data,
   input  logic                   pop,
   input  logic                   flush,
   output logic [$clog2(DEPTH):0] count,
   output logic [W-1:0]           head
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign do_pop  = pop & (count != '0);
   // A full FIFO can still take a push when the head leaves in the same cycle.
   assign do_push = push & ((count < CW'(DEPTH)) | do_pop);

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (rst && !flush && do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   assign head = mem[rd_ptr];

endmodule

// File: rtl/if_prefetch.sv
// rtl/if_prefetch.sv - credit-checked instruction prefetch between ICache and IQ
//
// Purpose: issues one ICache access at a time, parks responses in a fetch FIFO
//          and streams them to the IQ; a ROB redirect flushes the FIFO and
//          discards any access still in flight.
// Build option: IF_JAL_PREDICT_EN - when defined, a fetched JAL steers the next
//          fetch to its target and marks the entry as predicted.
// Ports:   clk         rising-edge clock
//          rst         synchronous active-low reset
//          rdy         global ready; low freezes all state
//          IC_success  one-cycle ICache completion pulse
//          IC_value    instruction returned with IC_success
//          IC_S        ICache request valid, held until IC_success
//          IC_pc       ICache request address
//          IQ_full     IQ cannot accept this cycle
//          IQ_S        one-cycle instruction valid to the IQ
//          IQ_Inst     instruction to the IQ
//          IQ_pc       pc of IQ_Inst
//          IQ_pred     next pc of IQ_Inst was predicted
//          ROB_Jump_S  redirect request
//          ROB_Jump    redirect target
module if_prefetch
   import riscv_pkg::*;
#(
   parameter int                ADDR_W   = ADDR_W_DEF,
   parameter int                INST_W   = INST_W_DEF,
   parameter int                FQ_DEPTH = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic              IC_success,
   input  logic [INST_W-1:0] IC_value,
   output logic              IC_S,
   output logic [ADDR_W-1:0] IC_pc,
   input  logic              IQ_full,
   output logic              IQ_S,
   output logic [INST_W-1:0] IQ_Inst,
   output logic [ADDR_W-1:0] IQ_pc,
   output logic              IQ_pred,
   input  logic              ROB_Jump_S,
   input  logic [ADDR_W-1:0] ROB_Jump
);

   localparam int CW = $clog2(FQ_DEPTH) + 1;
   localparam int EW = ADDR_W + INST_W + 1;

   logic [ADDR_W-1:0] pc;
   logic              pending;
   logic              drop;
   logic              push;
   logic              pop;
   logic              flush;
   logic              issue;
   logic              pred;
   logic [ADDR_W-1:0] next_pc;
   logic [CW-1:0]     count;
   logic [CW-1:0]     count_after;
   logic [EW-1:0]     head;

   // The request register doubles as the outstanding-access flag.
   assign IC_S = pending;

`ifdef IF_JAL_PREDICT_EN
   logic        is_jal;
   logic [20:0] jimm;
   assign jimm    = j_imm(IC_value[31:0]);
   assign is_jal  = (IC_value[6:0] == OPC_JAL);
   assign pred    = is_jal ? ENABLE : DISABLE;
   assign next_pc = is_jal ? IC_pc + {{(ADDR_W-21){jimm[20]}}, jimm}
                           : IC_pc + ADDR_W'(4);
`else
   assign pred    = DISABLE;
   assign next_pc = IC_pc + ADDR_W'(4);
`endif

   always_comb begin
      push  = rdy & IC_success & ~drop & ~ROB_Jump_S;
      pop   = rdy & ~ROB_Jump_S & ~IQ_full & (count != '0);
      flush = rdy & ROB_Jump_S;
      if (flush) count_after = '0;
      else       count_after = count + CW'(push) - CW'(pop);
      // A request is only launched when its response is guaranteed a slot.
      issue = rdy & ~pending & ~ROB_Jump_S & (count_after < CW'(FQ_DEPTH));
   end

   if_fetch_fifo #(
      .DEPTH (FQ_DEPTH),
      .W     (EW)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data ({IC_pc, IC_value, pred}),
      .pop       (pop),
      .flush     (flush),
      .count     (count),
      .head      (head)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         pc      <= RESET_PC;
         pending <= 1'b0;
         drop    <= 1'b0;
         IC_pc   <= '0;
         IQ_S    <= 1'b0;
         IQ_Inst <= '0;
         IQ_pc   <= '0;
         IQ_pred <= 1'b0;
      end else if (rdy) begin
         IQ_S <= pop;
         if (pop) begin
            IQ_pc   <= head[EW-1 -: ADDR_W];
            IQ_Inst <= head[INST_W:1];
            IQ_pred <= head[0];
         end

         if (IC_success) begin
            // Response closes the access; a dropped or same-cycle-redirected
            // one is simply not pushed.
            pending <= 1'b0;
            drop    <= 1'b0;
         end else if (ROB_Jump_S) begin
            // An access still in flight must be swallowed when it returns.
            drop <= pending;
         end else if (issue) begin
            pending <= 1'b1;
            IC_pc   <= pc;
         end

         if (ROB_Jump_S)  pc <= ROB_Jump;
         else if (push)   pc <= next_pc;
      end else begin
         IQ_S <= 1'b0;
      end
   end

endmodule

// File: tb/tb_if_prefetch.sv
// tb/tb_if_prefetch.sv - directed self-checking bench for if_prefetch
module tb_if_prefetch;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        pred;
   } iq_rec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        rdy;
   logic        IC_success = 1'b0;
   logic [31:0] IC_value   = '0;
   logic        IC_S;
   logic [31:0] IC_pc;
   logic        IQ_full;
   logic        IQ_S;
   logic [31:0] IQ_Inst;
   logic [31:0] IQ_pc;
   logic        IQ_pred;
   logic        ROB_Jump_S;
   logic [31:0] ROB_Jump;

   int checks   = 0;
   int failures = 0;
   int lat      = 1;
   bit jal_on   = 1'b0;
   bit busy     = 1'b0;
   int cnt      = 0;

   logic [31:0] reqs[$];
   iq_rec_t     iqs[$];

   if_prefetch dut (
      .clk        (clk),
      .rst        (rst),
      .rdy        (rdy),
      .IC_success (IC_success),
      .IC_value   (IC_value),
      .IC_S       (IC_S),
      .IC_pc      (IC_pc),
      .IQ_full    (IQ_full),
      .IQ_S       (IQ_S),
      .IQ_Inst    (IQ_Inst),
      .IQ_pc      (IQ_pc),
      .IQ_pred    (IQ_pred),
      .ROB_Jump_S (ROB_Jump_S),
      .ROB_Jump   (ROB_Jump)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mk(input logic [31:0] a);
      if (jal_on && a == 32'h20) return 32'h0100006F;
      return {a[24:0], 7'h13};
   endfunction

   function automatic logic [31:0] req_at(input int i);
      if (i < reqs.size()) return reqs[i];
      return 'x;
   endfunction

   function automatic logic [31:0] iq_pc_at(input int i);
      if (i < iqs.size()) return iqs[i].pc;
      return 'x;
   endfunction

   function automatic logic [31:0] iq_inst_at(input int i);
      if (i < iqs.size()) return iqs[i].inst;
      return 'x;
   endfunction

   function automatic logic iq_pred_at(input int i);
      if (i < iqs.size()) return iqs[i].pred;
      return 1'bx;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic do_reset(input int l, input logic full, input bit jal);
      rst        = 1'b0;
      rdy        = 1'b1;
      ROB_Jump_S = 1'b0;
      ROB_Jump   = '0;
      IQ_full    = full;
      lat        = l;
      jal_on     = jal;
      repeat (2) @(negedge clk);
      reqs.delete();
      iqs.delete();
      rst = 1'b1;
   endtask

   // ICache model: one access at a time, rdy-gated, answers after lat cycles.
   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (IC_success) begin
            IC_success = 1'b0;
            busy       = 1'b0;
         end
         if (!rst) begin
            busy = 1'b0;
         end else begin
            if (IC_S && !busy) begin
               busy = 1'b1;
               cnt  = 0;
               reqs.push_back(IC_pc);
            end
            if (busy && rdy) begin
               cnt++;
               if (cnt >= lat) begin
                  IC_success = 1'b1;
                  IC_value   = mk(IC_pc);
               end
            end
         end
      end
   end

   // IQ monitor: records every IQ_S pulse.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (IQ_S) iqs.push_back('{pc: IQ_pc, inst: IQ_Inst, pred: IQ_pred});
      end
   end

   initial begin
      logic [31:0] exp_next;
      logic        exp_pred;
      bit          found;

      // Reset state
      do_reset(1, 1'b0, 1'b0);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_ic_s", IC_S, 0);
      chk("rst_ic_pc", IC_pc, 0);
      chk("rst_iq_s", IQ_S, 0);
      chk("rst_iq_inst", IQ_Inst, 0);
      chk("rst_iq_pc", IQ_pc, 0);
      chk("rst_iq_pred", IQ_pred, 0);

      // Streaming with 1-cycle ICache
      do_reset(1, 1'b0, 1'b0);
      repeat (30) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("stream_req%0d", i), req_at(i), 32'(4 * i));
         chk($sformatf("stream_iqpc%0d", i), iq_pc_at(i), 32'(4 * i));
         chk($sformatf("stream_inst%0d", i), iq_inst_at(i), mk(32'(4 * i)));
         chk($sformatf("stream_pred%0d", i), iq_pred_at(i), 0);
      end

      // IQ full: credit check stops after FQ_DEPTH requests
      do_reset(1, 1'b1, 1'b0);
      repeat (20) @(negedge clk);
      chk("full_nreq", reqs.size(), 4);
      chk("full_ic_s", IC_S, 0);
      chk("full_niq", iqs.size(), 0);
      for (int i = 0; i < 4; i++) chk($sformatf("full_req%0d", i), req_at(i), 32'(4 * i));
      IQ_full = 1'b0;
      repeat (20) @(negedge clk);
      for (int i = 0; i < 5; i++) chk($sformatf("drain_iqpc%0d", i), iq_pc_at(i), 32'(4 * i));
      chk("drain_req4", req_at(4), 32'h10);

      // Redirect while a 3-cycle access to 0x8 is pending
      do_reset(3, 1'b1, 1'b0);
      found = 1'b0;
      for (int i = 0; i < 60 && !found; i++) begin
         @(negedge clk);
         if (IC_S && IC_pc == 32'h8) found = 1'b1;
      end
      chk("redir_found8", found, 1);
      ROB_Jump_S = 1'b1;
      ROB_Jump   = 32'h100;
      @(negedge clk);
      ROB_Jump_S = 1'b0;
      IQ_full    = 1'b0;
      chk("redir_ic_s_held", IC_S, 1);
      chk("redir_ic_pc_held", IC_pc, 32'h8);
      chk("redir_iq_s", IQ_S, 0);
      repeat (30) @(negedge clk);
      chk("redir_req3", req_at(3), 32'h100);
      chk("redir_iqpc0", iq_pc_at(0), 32'h100);
      chk("redir_inst0", iq_inst_at(0), mk(32'h100));
      chk("redir_iqpc1", iq_pc_at(1), 32'h104);

      // Redirect coincident with IC_success and a possible pop
      do_reset(1, 1'b1, 1'b0);
      repeat (3) @(negedge clk);
      chk("coin_pre_ic_s", IC_S, 1);
      chk("coin_pre_ic_pc", IC_pc, 32'h4);
      ROB_Jump_S = 1'b1;
      ROB_Jump   = 32'h200;
      IQ_full    = 1'b0;
      @(negedge clk);
      ROB_Jump_S = 1'b0;
      chk("coin_iq_s", IQ_S, 0);
      chk("coin_ic_s", IC_S, 0);
      chk("coin_niq", iqs.size(), 0);
      @(negedge clk);
      chk("coin_next_ic_s", IC_S, 1);
      chk("coin_next_ic_pc", IC_pc, 32'h200);
      repeat (10) @(negedge clk);
      chk("coin_iqpc0", iq_pc_at(0), 32'h200);

      // rdy low for 5 cycles mid-stream
      do_reset(1, 1'b0, 1'b0);
      repeat (5) @(negedge clk);
      chk("rdy_pre_ic_s", IC_S, 1);
      chk("rdy_pre_ic_pc", IC_pc, 32'h8);
      chk("rdy_pre_iq_s", IQ_S, 1);
      chk("rdy_pre_iq_pc", IQ_pc, 32'h4);
      rdy = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk($sformatf("rdy_low_iq_s%0d", i), IQ_S, 0);
         chk($sformatf("rdy_low_ic_s%0d", i), IC_S, 1);
         chk($sformatf("rdy_low_ic_pc%0d", i), IC_pc, 32'h8);
      end
      rdy = 1'b1;
      repeat (20) @(negedge clk);
      for (int i = 0; i < 6; i++) chk($sformatf("rdy_iqpc%0d", i), iq_pc_at(i), 32'(4 * i));

      // JAL at 0x20
      do_reset(1, 1'b0, 1'b1);
`ifdef IF_JAL_PREDICT_EN
      exp_next = 32'h30;
      exp_pred = 1'b1;
`else
      exp_next = 32'h24;
      exp_pred = 1'b0;
`endif
      repeat (40) @(negedge clk);
      chk("jal_req9", req_at(9), exp_next);
      chk("jal_iqpc8", iq_pc_at(8), 32'h20);
      chk("jal_inst8", iq_inst_at(8), 32'h0100006F);
      chk("jal_pred8", iq_pred_at(8), exp_pred);
      chk("jal_iqpc9", iq_pc_at(9), exp_next);
      chk("jal_pred9", iq_pred_at(9), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
